// File: rtl/ledport_pwm_fta64_if.sv
// FTA 64-bit command bus payload types and the chip-select/request/response bundle
// seen by the LED port.
package ledport_pwm_fta64_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_ERC     = 3'b111;
    localparam logic [1:0] ERR_OKAY    = 2'b00;

    typedef struct packed {
        logic        cyc;
        logic        we;
        logic [2:0]  cti;
        logic [12:0] tid;
        logic [31:0] padr;
        logic [7:0]  sel;
        logic [63:0] dat;
    } fta_cmd_request64_t;

    typedef struct packed {
        logic        ack;
        logic [12:0] tid;
        logic [31:0] adr;
        logic [1:0]  err;
        logic        rty;
        logic [3:0]  pri;
        logic [63:0] dat;
    } fta_cmd_response64_t;

endpackage

interface ledport_pwm_fta64_if;
    import ledport_pwm_fta64_pkg::*;

    logic                cs;
    fta_cmd_request64_t  req;
    fta_cmd_response64_t resp;

    modport master (output cs, output req, input  resp);
    modport slave  (input  cs, input  req, output resp);

endinterface

// File: rtl/ledport_pwm_fta64.sv
// LED port on the FTA64 bus: NLED outputs, each static, blink, PWM or heartbeat.
// A power-on heartbeat drives every LED until software first writes the port.
module ledport_pwm_fta64
    import ledport_pwm_fta64_pkg::*;
#(
    parameter int unsigned NLED  = 8,
    parameter int unsigned HB_W  = 26,
    parameter int unsigned BLK_W = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    ledport_pwm_fta64_if.slave     bus,
    output logic [NLED-1:0]        led
);

    localparam int unsigned MODE_W = 2 * NLED;
    localparam int unsigned DUTY_W = 8 * NLED;

    localparam logic [1:0] ADR_VAL   = 2'd0;
    localparam logic [1:0] ADR_MODE  = 2'd1;
    localparam logic [1:0] ADR_DUTY  = 2'd2;

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_BLINK  = 2'b01;
    localparam logic [1:0] MODE_PWM    = 2'b10;

    logic [NLED-1:0]   r_val;
    logic [MODE_W-1:0] r_mode;
    logic [DUTY_W-1:0] r_duty;
    logic [BLK_W-1:0]  r_blink;
    logic              r_init;

    logic [HB_W-1:0]   r_cnt;
    logic [7:0]        r_pwm;
    logic [BLK_W-1:0]  r_bcnt;
    logic              r_phase;

    logic [NLED-1:0]     r_led;
    fta_cmd_response64_t r_resp;

    logic              w_wr;
    logic              w_rd;
    logic              w_ack;
    logic [1:0]        w_sel;
    logic              w_hb;
    logic              w_blink_wr;
    logic [63:0]       w_rdata;
    logic [NLED-1:0]   w_led_nxt;
    logic              w_unused_req;

    assign w_sel      = bus.req.padr[4:3];
    assign w_wr       = bus.cs & bus.req.we;
    assign w_rd       = bus.cs & ~bus.req.we;
    assign w_ack      = bus.cs & (~bus.req.we | (bus.req.cti == CTI_ERC));
    assign w_hb       = r_cnt[HB_W-1];
    assign w_blink_wr = w_wr & (w_sel == 2'd3);

    // Fields of the request this port never looks at.
    assign w_unused_req = ^bus.req;

    // Register write; any write ends the power-on heartbeat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val   <= '0;
            r_mode  <= '0;
            r_duty  <= '0;
            r_blink <= '0;
            r_init  <= 1'b0;
        end else if (w_wr) begin
            r_init <= 1'b1;
            case (w_sel)
                ADR_VAL:  r_val   <= bus.req.dat[NLED-1:0];
                ADR_MODE: r_mode  <= bus.req.dat[MODE_W-1:0];
                ADR_DUTY: r_duty  <= bus.req.dat[DUTY_W-1:0];
                default:  r_blink <= bus.req.dat[BLK_W-1:0];
            endcase
        end
    end

    // Free-running heartbeat and PWM ramp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_pwm <= '0;
        end else begin
            r_cnt <= r_cnt + HB_W'(1);
            r_pwm <= r_pwm + 8'd1;
        end
    end

    // Blink half-period counter; a zero period parks the phase dark.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (w_blink_wr || (r_blink == '0)) begin
            r_bcnt  <= '0;
            r_phase <= 1'b0;
        end else if (r_bcnt == r_blink) begin
            r_bcnt  <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_bcnt  <= r_bcnt + BLK_W'(1);
        end
    end

    // Per-LED source select from the current (pre-write) register values.
    always_comb begin
        w_led_nxt = '0;
        for (int i = 0; i < int'(NLED); i++) begin
            case (r_mode[2*i +: 2])
                MODE_STATIC: w_led_nxt[i] = r_val[i];
                MODE_BLINK:  w_led_nxt[i] = r_val[i] & r_phase;
                MODE_PWM:    w_led_nxt[i] = (r_pwm < r_duty[8*i +: 8]);
                default:     w_led_nxt[i] = w_hb;
            endcase
        end
        if (!r_init) begin
            w_led_nxt = {NLED{w_hb}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_led <= '0;
        end else begin
            r_led <= w_led_nxt;
        end
    end

    // Read-back mux; unused bits read as zero, init flag rides on BLINK bit 63.
    always_comb begin
        w_rdata = '0;
        case (w_sel)
            ADR_VAL:  w_rdata = 64'(r_val);
            ADR_MODE: w_rdata = 64'(r_mode);
            ADR_DUTY: w_rdata = 64'(r_duty);
            default: begin
                w_rdata     = 64'(r_blink);
                w_rdata[63] = r_init;
            end
        endcase
    end

    // Single-cycle response; plain writes are posted and get no ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp <= '0;
        end else begin
            r_resp.ack <= w_ack;
            r_resp.tid <= bus.req.tid;
            r_resp.adr <= bus.req.padr;
            r_resp.err <= ERR_OKAY;
            r_resp.rty <= 1'b0;
            r_resp.pri <= 4'd7;
            r_resp.dat <= w_rd ? w_rdata : 64'd0;
        end
    end

    assign bus.resp = r_resp;
    assign led      = r_led;

endmodule
